stack_sequencer: RTL

//  Walks a push/pop register bitmask (STACK_* encoding from the pre-decode push/pop fields) and issues one

---
 rtl/stack_sequencer_pkg.sv | 9 +
 rtl/stack_sequencer_if.sv | 11 +
 rtl/stack_sequencer_mask_pick.sv | 18 +
 rtl/stack_sequencer.sv | 118 +++++++++++
 4 files changed

// File: rtl/stack_sequencer_pkg.sv
// stack_sequencer_pkg: shared state encoding, mask constants and linear-address helper for the stack sequencer
package stack_sequencer_pkg;
  typedef enum logic [1:0] {SS_IDLE, SS_SELECT, SS_ACCESS, SS_FINISH} stack_seq_state_e;
  localparam int STACK_SP_DISCARD_BIT = 5;
  localparam int STACK_LIN_AW = 20;
  function automatic logic [STACK_LIN_AW-1:0] stack_lin_addr(input logic [15:0] ss, input logic [STACK_LIN_AW-1:0] off);
    return {ss, 4'h0} + off;
  endfunction
endpackage

// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if: stack bus request/acknowledge channel between sequencer and bus interface unit
interface stack_sequencer_if #(parameter int AW = 16, parameter int DW = 16);
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  modport master (output bus_req, bus_we, bus_addr, bus_wdata, input bus_ack, bus_rdata);
  modport slave (input bus_req, bus_we, bus_addr, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/stack_sequencer_mask_pick.sv
// stack_mask_pick: combinational lowest/highest set-bit encoder
module stack_mask_pick #(parameter int W = 16) (
  input  logic [W-1:0]         mask,
  input  logic                 pick_high,
  output logic [$clog2(W)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(W);
  logic [IW-1:0] lo, hi;
  always_comb begin
    lo = '0;
    hi = '0;
    for (int i = W - 1; i >= 0; i--) lo = mask[i] ? IW'(i) : lo;
    for (int i = 0; i < W; i++) hi = mask[i] ? IW'(i) : hi;
  end
  assign idx = pick_high ? hi : lo;
  assign any = |mask;
endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: walks a push/pop mask issuing one stack access per set bit; STACK_SEQ_LINEAR_ADDR_EN adds ss_in segment addressing
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int MASK_W      = 16,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int STEP        = 2,
  parameter int DISCARD_BIT = STACK_SP_DISCARD_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      is_pop,
  input  logic [MASK_W-1:0]         mask,
  input  logic [ADDR_W-1:0]         sp_in,
`ifdef STACK_SEQ_LINEAR_ADDR_EN
  input  logic [15:0]               ss_in,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(MASK_W)-1:0] reg_sel,
  input  logic [DATA_W-1:0]         reg_rdata,
  stack_sequencer_if.master         bus,
  output logic                      wb_valid,
  output logic [DATA_W-1:0]         wb_data,
  output logic [ADDR_W-1:0]         sp_out,
  output logic                      sp_wr
);
  localparam int IW = $clog2(MASK_W);
  stack_seq_state_e  state, state_n;
  logic [MASK_W-1:0] pend;
  logic [ADDR_W-1:0] sp_r, off_n;
  logic              dir, any, skip, we_r;
  logic [IW-1:0]     pick_idx, idx_r;
  logic [DATA_W-1:0] wdata_r;
`ifdef STACK_SEQ_LINEAR_ADDR_EN
  logic [15:0]             ss_r;
  logic [STACK_LIN_AW-1:0] addr_r, addr_n;
`else
  logic [ADDR_W-1:0]       addr_r, addr_n;
`endif
  stack_mask_pick #(.W(MASK_W)) u_pick (.mask(pend), .pick_high(dir), .idx(pick_idx), .any(any));
  assign skip  = any && pick_idx == IW'(DISCARD_BIT);
  assign off_n = dir ? sp_r : sp_r - ADDR_W'(STEP);
`ifdef STACK_SEQ_LINEAR_ADDR_EN
  assign addr_n = stack_lin_addr(ss_r, STACK_LIN_AW'(off_n));
`else
  assign addr_n = off_n;
`endif
  always_comb begin
    state_n = state;
    case (state)
      SS_IDLE:   state_n = start ? SS_SELECT : SS_IDLE;
      SS_SELECT: state_n = !any ? SS_FINISH : skip ? SS_SELECT : SS_ACCESS;
      SS_ACCESS: state_n = bus.bus_ack ? SS_SELECT : SS_ACCESS;
      default:   state_n = SS_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= SS_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      sp_r     <= '0;
      dir      <= 1'b0;
      idx_r    <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
      we_r     <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      sp_out   <= '0;
`ifdef STACK_SEQ_LINEAR_ADDR_EN
      ss_r     <= '0;
`endif
    end else begin
      wb_valid <= 1'b0;
      case (state)
        SS_IDLE: if (start) begin
          pend <= mask;
          sp_r <= sp_in;
          dir  <= is_pop;
`ifdef STACK_SEQ_LINEAR_ADDR_EN
          ss_r <= ss_in;
`endif
        end
        SS_SELECT: if (!any) sp_out <= sp_r;
          else if (skip) begin
            pend[pick_idx] <= 1'b0;
            if (dir) sp_r <= sp_r + ADDR_W'(STEP);
          end else begin
            idx_r   <= pick_idx;
            addr_r  <= addr_n;
            wdata_r <= reg_rdata;
            we_r    <= !dir;
          end
        SS_ACCESS: if (bus.bus_ack) begin
          pend[idx_r] <= 1'b0;
          sp_r        <= dir ? sp_r + ADDR_W'(STEP) : sp_r - ADDR_W'(STEP);
          wb_valid    <= dir;
          if (dir) wb_data <= bus.bus_rdata;
        end
        default: ;
      endcase
    end
  end
  // writeback cycle keeps the popped item selected; otherwise SELECT shows the next pick to the reg file
  assign reg_sel       = (state == SS_SELECT && !wb_valid) ? pick_idx : idx_r;
  assign busy          = state != SS_IDLE;
  assign done          = state == SS_FINISH;
  assign sp_wr         = state == SS_FINISH;
  assign bus.bus_req   = state == SS_ACCESS;
  assign bus.bus_we    = we_r;
  assign bus.bus_addr  = addr_r;
  assign bus.bus_wdata = wdata_r;
endmodule
